cnt_scan7: RTL and testbench
============================

# cnt_scan7

Display stage for the 4-bit counter output. It registers the incoming count and converts it to two decimal digits (00–15). It counts the counter's 15→0 wrap events in a BCD register (00–99). It time-multiplexes all four digits onto one 7-segment bus with one-hot digit anodes. It sits directly downstream of the 4-bit counter and drives the board's 4-digit display.

## Interface
- SCAN_DIV, 4: CLK0 cycles each digit stays selected; legal 1..65535.
- CLK0  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- cnt_in  in  4  count value from the upstream counter, binary 0..15.
- clr  in  1  synchronous clear of the wrap counter, active-high.
- seg  out  7  segment drive {g,f,e,d,c,b,a}, active-high, registered.
- an  out  4  digit enable, active-low one-hot, registered; an[0] = rightmost digit.
- wrap_bcd  out  8  wrap count, BCD {tens,ones}, registered.

## Operation
- Input register: cnt_q <= cnt_in every edge.
- Wrap detect: a wrap occurs at an edge where cnt_q == 15 and cnt_in == 0. No other transition counts, including 15→1 and 14→0.
- Wrap counter (wrap_bcd):
  - Priority 1: clr = 1 → 00.
  - Priority 2: wrap → BCD increment. Ones 9→0 carries into tens; 99 → 00.
  - Otherwise hold.
  - clr and wrap on the same edge → 00; the wrap is dropped.
- Digit values (from registered state, not from cnt_in):
  - d0 = cnt_q mod 10.
  - d1 = 1 if cnt_q ≥ 10, else 0.
  - d2 = wrap_bcd[3:0].
  - d3 = wrap_bcd[7:4].
- Leading-zero blanking:
  - d1 is blank when cnt_q < 10.
  - d3 is blank when it is 0.
  - d0 and d2 are never blank.
- Segment codes: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, blank=00.
- Scan state machine:
  - State idx ∈ {D0, D1, D2, D3}; transitions D0→D1→D2→D3→D0.
  - 16-bit prescaler pre counts 0..SCAN_DIV-1.
  - When pre == SCAN_DIV-1: pre <= 0 and idx advances.
  - Otherwise pre increments.
  - SCAN_DIV = 1 → idx advances every edge.
- Output register, every edge:
  - an <= active-low one-hot of idx (D0 → 1110, D1 → 1101, D2 → 1011, D3 → 0111).
  - seg <= code of the digit selected by idx, computed from pre-edge state.

## Timing
- Reset (RST low, asynchronous): cnt_q = 0, wrap_bcd = 00, pre = 0, idx = D0, seg = 00, an = 1111 (display dark).
- First rising edge after RST release: an = 1110, seg = code(d0 of cnt_q = 0) = 3F.
- cnt_in → seg: 2 edges (cnt_q register, then output register), counted while the affected digit is selected.
- Wrap → wrap_bcd: updates on the same edge cnt_q captures 0. Appears on seg one edge later while D2/D3 is selected.
- Each anode is low for exactly SCAN_DIV consecutive cycles; the full frame is 4·SCAN_DIV cycles.
- seg and an always change on the same edge; no cycle has two anodes low.
- RST asserted mid-frame: outputs go dark immediately and the scan restarts at D0 after release. clr does not affect the scan.

## Test plan
- Reset and scan:
  - Stimulus: SCAN_DIV = 4, cnt_in = 0, RST pulse.
  - Required: an = 1111 and seg = 00 during reset.
  - Then an = 1110 ×4, 1101 ×4, 1011 ×4, 0111 ×4, repeating.
  - seg = 3F, 00, 3F, 00 per digit (d1 blank, d2 = 0 shown, d3 blank).
- Decimal split:
  - Stimulus: cnt_in held at 13.
  - Required: D0 shows 4F and D1 shows 06.
  - Repeat with cnt_in = 7: D0 shows 07 and D1 shows 00.
- Wrap counting:
  - Stimulus: drive 0..15 repeating for 3 full cycles.
  - Required: wrap_bcd = 01, 02, 03, each updating on the edge where cnt_q captures 0.
  - Stimulus: drive 15→1 and 14→0.
  - Required: no increment.
- BCD carry and rollover:
  - Stimulus: preload 09 via wraps, then one more wrap.
  - Required: wrap_bcd = 10; D3 shows 06, D2 shows 3F.
  - From 99, one wrap → 00 and D3 blanks.
- clr priority:
  - Stimulus: assert clr on the same edge as a wrap, with wrap_bcd = 42.
  - Required: wrap_bcd = 00 on that edge; the next wrap gives 01.
- Async reset mid-frame and SCAN_DIV = 1:
  - Stimulus: assert RST while an = 1011.
  - Required: an = 1111 immediately, with no clock edge needed.
  - Stimulus: rerun with SCAN_DIV = 1.
  - Required: an rotates every cycle.

Source files
------------

// File: rtl/cnt_scan7.sv
// cnt_scan7 -- display stage for a 4-bit counter.
//
// Registers the incoming count and splits it into two decimal digits (00..15).
// Counts the upstream counter's 15->0 wrap events in a two-digit BCD register
// (00..99). Time-multiplexes all four digits onto one 7-segment bus.
//
// Ports:
//   CLK0      in   clock; all state updates on the rising edge
//   RST       in   asynchronous, active-low reset
//   cnt_in    in   [3:0] count from the upstream counter (0..15)
//   clr       in   synchronous clear of the wrap counter, active-high
//   seg       out  [6:0] segments {g,f,e,d,c,b,a}, active-high, registered
//   an        out  [3:0] digit enables, active-low one-hot, registered;
//                  an[0] is the rightmost digit
//   wrap_bcd  out  [7:0] wrap count {tens,ones} in BCD, registered
//
// Parameter:
//   SCAN_DIV  CLK0 cycles each digit stays selected (1..65535)
module cnt_scan7 #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic       CLK0,
  input  logic       RST,
  input  logic [3:0] cnt_in,
  input  logic       clr,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [7:0] wrap_bcd
);

  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2,
    D3 = 2'd3
  } idx_t;

  localparam logic [15:0] PRE_LAST = 16'(SCAN_DIV - 1);

  idx_t        idx, idx_nxt;
  logic [15:0] pre, pre_nxt;
  logic [3:0]  cnt_q;
  logic        wrap;
  logic [7:0]  wrap_nxt;
  logic [3:0]  digit;
  logic        blank;
  logic [6:0]  seg_nxt;
  logic [3:0]  an_nxt;

  // Segment pattern for a decimal digit; anything above 9 shows dark.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h00;
    endcase
  endfunction

  // Only the exact 15 -> 0 step is a wrap; 15 -> 1 or 14 -> 0 is not.
  assign wrap = (cnt_q == 4'd15) && (cnt_in == 4'd0);

  // Wrap counter next value: clear wins over a coincident wrap.
  always_comb begin
    wrap_nxt = wrap_bcd;
    if (clr) begin
      wrap_nxt = 8'h00;
    end else if (wrap) begin
      if (wrap_bcd[3:0] == 4'd9) begin
        wrap_nxt[3:0] = 4'd0;
        wrap_nxt[7:4] = (wrap_bcd[7:4] == 4'd9) ? 4'd0 : wrap_bcd[7:4] + 4'd1;
      end else begin
        wrap_nxt[3:0] = wrap_bcd[3:0] + 4'd1;
      end
    end
  end

  // Scan FSM: state register.
  always_ff @(posedge CLK0 or negedge RST) begin
    if (!RST) begin
      idx <= D0;
      pre <= 16'd0;
    end else begin
      idx <= idx_nxt;
      pre <= pre_nxt;
    end
  end

  // Scan FSM: prescaler and digit advance.
  always_comb begin
    pre_nxt = pre + 16'd1;
    idx_nxt = idx;
    if (pre == PRE_LAST) begin
      pre_nxt = 16'd0;
      case (idx)
        D0:      idx_nxt = D1;
        D1:      idx_nxt = D2;
        D2:      idx_nxt = D3;
        default: idx_nxt = D0;
      endcase
    end
  end

  // Digit selection from registered state only, with leading-zero blanking
  // on the tens digits (d1 and d3).
  always_comb begin
    digit = 4'd0;
    blank = 1'b0;
    an_nxt = 4'b1111;
    case (idx)
      D0: begin
        digit  = (cnt_q >= 4'd10) ? cnt_q - 4'd10 : cnt_q;
        an_nxt = 4'b1110;
      end
      D1: begin
        digit  = 4'd1;
        blank  = (cnt_q < 4'd10);
        an_nxt = 4'b1101;
      end
      D2: begin
        digit  = wrap_bcd[3:0];
        an_nxt = 4'b1011;
      end
      default: begin
        digit  = wrap_bcd[7:4];
        blank  = (wrap_bcd[7:4] == 4'd0);
        an_nxt = 4'b0111;
      end
    endcase
    seg_nxt = blank ? 7'h00 : seg_code(digit);
  end

  // Data path and output registers. seg/an follow idx by one edge, so both
  // change together and the display stays dark until the first edge.
  always_ff @(posedge CLK0 or negedge RST) begin
    if (!RST) begin
      cnt_q    <= 4'd0;
      wrap_bcd <= 8'h00;
      seg      <= 7'h00;
      an       <= 4'b1111;
    end else begin
      cnt_q    <= cnt_in;
      wrap_bcd <= wrap_nxt;
      seg      <= seg_nxt;
      an       <= an_nxt;
    end
  end

endmodule

// File: tb/tb_cnt_scan7.sv
// Testbench for cnt_scan7: two instances (SCAN_DIV = 4 and 1) share inputs.
// A reference model pushes expected {seg, an, wrap_bcd} per edge into a
// queue; a monitor pops and compares after each edge. Feature tasks add
// directed checks against fixed values.
module tb_cnt_scan7;

  logic       CLK0;
  logic       RST;
  logic [3:0] cnt_in;
  logic       clr;
  logic [6:0] seg4, seg1;
  logic [3:0] an4, an1;
  logic [7:0] wrap4, wrap1;

  int checks = 0;
  int errors = 0;

  logic [18:0] exp_q[$];

  // Reference model state
  int m_cnt;
  int m_wrap;
  int m_pre[2];
  int m_idx[2];
  int div_k[2] = '{4, 1};

  cnt_scan7 #(.SCAN_DIV(4)) dut4 (
    .CLK0(CLK0), .RST(RST), .cnt_in(cnt_in), .clr(clr),
    .seg(seg4), .an(an4), .wrap_bcd(wrap4)
  );

  cnt_scan7 #(.SCAN_DIV(1)) dut1 (
    .CLK0(CLK0), .RST(RST), .cnt_in(cnt_in), .clr(clr),
    .seg(seg1), .an(an1), .wrap_bcd(wrap1)
  );

  // Clock / reset block
  initial CLK0 = 1'b0;
  always #5 CLK0 = ~CLK0;

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: ref_seg = 7'h3F;  1: ref_seg = 7'h06;  2: ref_seg = 7'h5B;
      3: ref_seg = 7'h4F;  4: ref_seg = 7'h66;  5: ref_seg = 7'h6D;
      6: ref_seg = 7'h7D;  7: ref_seg = 7'h07;  8: ref_seg = 7'h7F;
      9: ref_seg = 7'h6F;
      default: ref_seg = 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] ref_digit_seg(input int i);
    int d;
    case (i)
      0: d = m_cnt % 10;
      1: d = (m_cnt >= 10) ? 1 : -1;
      2: d = m_wrap % 10;
      default: d = (m_wrap / 10 == 0) ? -1 : m_wrap / 10;
    endcase
    return ref_seg(d);
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  // Driver tasks
  task automatic model_reset();
    m_cnt = 0;
    m_wrap = 0;
    for (int k = 0; k < 2; k++) begin
      m_pre[k] = 0;
      m_idx[k] = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge CLK0); #1;
    RST = 1'b0;
    cnt_in = 4'd0;
    clr = 1'b0;
    model_reset();
    @(posedge CLK0); #2;
    RST = 1'b1;
  endtask

  // Drive one cycle of inputs, record the expected post-edge outputs.
  task automatic step(input logic [3:0] c, input logic cl);
    int nw;
    logic [3:0] a;
    cnt_in = c;
    clr = cl;
    if (cl) nw = 0;
    else if (m_cnt == 15 && c == 4'd0) nw = (m_wrap + 1) % 100;
    else nw = m_wrap;
    for (int k = 0; k < 2; k++) begin
      a = 4'b1111;
      a[m_idx[k]] = 1'b0;
      exp_q.push_back({ref_digit_seg(m_idx[k]), a, to_bcd(nw)});
      if (m_pre[k] == div_k[k] - 1) begin
        m_pre[k] = 0;
        m_idx[k] = (m_idx[k] + 1) % 4;
      end else begin
        m_pre[k]++;
      end
    end
    m_cnt = int'(c);
    m_wrap = nw;
    @(posedge CLK0); #2;
  endtask

  task automatic do_wrap();
    step(4'd15, 1'b0);
    step(4'd0, 1'b0);
  endtask

  // Scoreboard monitor
  always @(posedge CLK0) begin
    logic [18:0] e4, e1;
    #1;
    if (exp_q.size() >= 2) begin
      e4 = exp_q.pop_front();
      e1 = exp_q.pop_front();
      checks++;
      if ({seg4, an4, wrap4} !== e4) begin
        errors++;
        $display("FAIL sb_div4 seg/an/wrap got %h/%b/%h exp %h/%b/%h",
                 seg4, an4, wrap4, e4[18:12], e4[11:8], e4[7:0]);
      end
      checks++;
      if ({seg1, an1, wrap1} !== e1) begin
        errors++;
        $display("FAIL sb_div1 seg/an/wrap got %h/%b/%h exp %h/%b/%h",
                 seg1, an1, wrap1, e1[18:12], e1[11:8], e1[7:0]);
      end
    end
  end

  task automatic test_reset();
    logic [3:0] an_tab[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] seg_tab[4] = '{7'h3F, 7'h00, 7'h3F, 7'h00};
    @(posedge CLK0); #1;
    RST = 1'b0;
    model_reset();
    #2;
    checks++;
    if (an4 !== 4'b1111 || seg4 !== 7'h00 || wrap4 !== 8'h00) begin
      errors++;
      $display("FAIL reset_dark an/seg/wrap got %b/%h/%h exp 1111/00/00", an4, seg4, wrap4);
    end
    @(posedge CLK0); #2;
    RST = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step(4'd0, 1'b0);
      checks++;
      if (an4 !== an_tab[(i / 4) % 4] || seg4 !== seg_tab[(i / 4) % 4]) begin
        errors++;
        $display("FAIL scan_cycle%0d an/seg got %b/%h exp %b/%h", i, an4, seg4,
                 an_tab[(i / 4) % 4], seg_tab[(i / 4) % 4]);
      end
    end
  endtask

  task automatic test_decimal_split(input logic [3:0] v, input logic [6:0] s0,
                                    input logic [6:0] s1);
    int hits = 0;
    step(v, 1'b0);
    step(v, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(v, 1'b0);
      if (an4 == 4'b1110) begin
        hits++;
        checks++;
        if (seg4 !== s0) begin
          errors++;
          $display("FAIL split_d0 cnt=%0d got %h exp %h", v, seg4, s0);
        end
      end else if (an4 == 4'b1101) begin
        hits++;
        checks++;
        if (seg4 !== s1) begin
          errors++;
          $display("FAIL split_d1 cnt=%0d got %h exp %h", v, seg4, s1);
        end
      end
    end
    checks++;
    if (hits != 8) begin
      errors++;
      $display("FAIL split_hits cnt=%0d got %0d exp 8", v, hits);
    end
  endtask

  task automatic test_wrap_count();
    int w = 0;
    logic [3:0] prev = 4'd0;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int v = 0; v < 16; v++) begin
        step(4'(v), 1'b0);
        if (v == 0 && prev == 4'd15) begin
          w++;
          checks++;
          if (wrap4 !== 8'(w)) begin
            errors++;
            $display("FAIL wrap_count got %h exp %h", wrap4, 8'(w));
          end
        end
        prev = 4'(v);
      end
    end
    step(4'd0, 1'b0);
    checks++;
    if (wrap4 !== 8'h03) begin
      errors++;
      $display("FAIL wrap_third got %h exp 03", wrap4);
    end
    step(4'd15, 1'b0);
    step(4'd1, 1'b0);
    step(4'd14, 1'b0);
    step(4'd0, 1'b0);
    checks++;
    if (wrap4 !== 8'h03) begin
      errors++;
      $display("FAIL no_false_wrap got %h exp 03", wrap4);
    end
  endtask

  task automatic test_bcd_carry();
    int hits = 0;
    for (int i = 0; i < 6; i++) do_wrap();
    checks++;
    if (wrap4 !== 8'h09) begin
      errors++;
      $display("FAIL preload_09 got %h exp 09", wrap4);
    end
    do_wrap();
    checks++;
    if (wrap4 !== 8'h10) begin
      errors++;
      $display("FAIL carry_10 got %h exp 10", wrap4);
    end
    for (int i = 0; i < 17; i++) begin
      step(4'd0, 1'b0);
      if (an4 == 4'b0111) begin
        hits++;
        checks++;
        if (seg4 !== 7'h06) begin
          errors++;
          $display("FAIL carry_d3 got %h exp 06", seg4);
        end
      end else if (an4 == 4'b1011) begin
        hits++;
        checks++;
        if (seg4 !== 7'h3F) begin
          errors++;
          $display("FAIL carry_d2 got %h exp 3F", seg4);
        end
      end
    end
    for (int i = 0; i < 89; i++) do_wrap();
    checks++;
    if (wrap4 !== 8'h99) begin
      errors++;
      $display("FAIL reach_99 got %h exp 99", wrap4);
    end
    do_wrap();
    checks++;
    if (wrap4 !== 8'h00) begin
      errors++;
      $display("FAIL rollover_00 got %h exp 00", wrap4);
    end
    for (int i = 0; i < 17; i++) begin
      step(4'd0, 1'b0);
      if (an4 == 4'b0111) begin
        hits++;
        checks++;
        if (seg4 !== 7'h00) begin
          errors++;
          $display("FAIL rollover_d3_blank got %h exp 00", seg4);
        end
      end
    end
    checks++;
    if (hits < 12) begin
      errors++;
      $display("FAIL carry_hits got %0d exp >=12", hits);
    end
  endtask

  task automatic test_clr_priority();
    do_reset();
    for (int i = 0; i < 42; i++) do_wrap();
    checks++;
    if (wrap4 !== 8'h42) begin
      errors++;
      $display("FAIL preload_42 got %h exp 42", wrap4);
    end
    step(4'd15, 1'b0);
    step(4'd0, 1'b1);
    checks++;
    if (wrap4 !== 8'h00) begin
      errors++;
      $display("FAIL clr_wins got %h exp 00", wrap4);
    end
    clr = 1'b0;
    do_wrap();
    checks++;
    if (wrap4 !== 8'h01) begin
      errors++;
      $display("FAIL after_clr got %h exp 01", wrap4);
    end
  endtask

  task automatic test_async_reset_mid_frame();
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(4'd5, 1'b0);
      if (an4 == 4'b1011) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_d2 an got %b exp 1011 within 20 cycles", an4);
    end
    RST = 1'b0;
    model_reset();
    #1;
    checks++;
    if (an4 !== 4'b1111 || seg4 !== 7'h00 || an1 !== 4'b1111 || wrap4 !== 8'h00) begin
      errors++;
      $display("FAIL async_dark an4/seg4/an1/wrap got %b/%h/%b/%h exp 1111/00/1111/00",
               an4, seg4, an1, wrap4);
    end
    @(posedge CLK0); #2;
    RST = 1'b1;
    step(4'd5, 1'b0);
    checks++;
    if (an4 !== 4'b1110 || seg4 !== 7'h3F) begin
      errors++;
      $display("FAIL restart_d0 an/seg got %b/%h exp 1110/3F", an4, seg4);
    end
  endtask

  task automatic test_scan_div1();
    logic [3:0] an_tab[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(4'($urandom_range(0, 15)), 1'b0);
      checks++;
      if (an1 !== an_tab[i % 4]) begin
        errors++;
        $display("FAIL div1_rotate cycle%0d got %b exp %b", i, an1, an_tab[i % 4]);
      end
    end
    for (int i = 0; i < 200; i++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 31) == 0));
    end
    clr = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    cnt_in = 4'd0;
    clr = 1'b0;
    model_reset();
    test_reset();
    test_decimal_split(4'd13, 7'h4F, 7'h06);
    test_decimal_split(4'd7, 7'h07, 7'h00);
    test_wrap_count();
    test_bcd_carry();
    test_clr_priority();
    test_async_reset_mid_frame();
    test_scan_div1();
    @(posedge CLK0); #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d exp 0 entries left", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
